// File: rtl/keypad_event_encoder.sv
// keypad_event_encoder: synchronises and debounces 12 keypad buttons and queues their
// press/release events in a show-ahead FIFO. Define KEY_REPEAT_EN for held-key auto-repeat.
module keypad_event_encoder #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int FIFO_DEPTH      = 4,
  parameter int REPEAT_DELAY    = 16,
  parameter int REPEAT_PERIOD   = 8
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        BTN1,
  input  logic        BTN2,
  input  logic        BTN3,
  input  logic        BTN4,
  input  logic        BTN5,
  input  logic        BTN6,
  input  logic        BTN7,
  input  logic        BTN8,
  input  logic        BTN9,
  input  logic        BTN_0,
  input  logic        BTN_star,
  input  logic        BTN_sharp,
  output logic        key_valid,
  input  logic        key_ready,
  output logic [3:0]  key_code,
  output logic        key_release,
  output logic        key_repeat,
  output logic [11:0] held_mask,
  output logic        overflow
);

  localparam int NK   = 12;
  localparam int CW   = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int CNTW = AW + 1;
`ifdef KEY_REPEAT_EN
  localparam int EW   = 6;
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = $clog2(RMAX + 1);
`else
  localparam int EW   = 5;
`endif

  // Bit n of every key vector carries the key whose code is n.
  logic [NK-1:0] raw;
  assign raw = {BTN_sharp, BTN_star, BTN9, BTN8, BTN7, BTN6, BTN5, BTN4, BTN3, BTN2, BTN1, BTN_0};

  logic [NK-1:0] sync1, sync2, deb, deb_d;
  logic [CW-1:0] db_cnt [NK];

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync1 <= '0;
      sync2 <= '0;
      deb   <= '0;
      deb_d <= '0;
      for (int n = 0; n < NK; n++) db_cnt[n] <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      deb_d <= deb;
      for (int n = 0; n < NK; n++) begin
        if (sync2[n] == deb[n]) begin
          db_cnt[n] <= '0;
        end else if (db_cnt[n] == CW'(DEBOUNCE_CYCLES - 1)) begin
          deb[n]    <= sync2[n];
          db_cnt[n] <= '0;
        end else begin
          db_cnt[n] <= db_cnt[n] + CW'(1);
        end
      end
    end
  end

  assign held_mask = deb;

  logic [NK-1:0] rise, fall;
  assign rise = deb & ~deb_d;
  assign fall = ~deb & deb_d;

  logic [NK-1:0] press_pend, rel_pend;
  logic [NK-1:0] clr_press, clr_rel;
  logic          sel_found, sel_rel;
  logic [3:0]    sel_code;
  logic          push, pop, full;
  logic [EW-1:0] push_data;
  logic [CNTW-1:0] count;

`ifdef KEY_REPEAT_EN
  logic          rep_pend, sel_rep, clr_rep;
  logic [3:0]    rep_code;
`endif

  // Lowest code wins; within a key the press goes out before the release.
  always_comb begin
    sel_found = 1'b0;
    sel_rel   = 1'b0;
    sel_code  = 4'd0;
    for (int n = 0; n < NK; n++) begin
      if (!sel_found && (press_pend[n] || rel_pend[n])) begin
        sel_found = 1'b1;
        sel_rel   = !press_pend[n];
        sel_code  = 4'(n);
      end
    end
`ifdef KEY_REPEAT_EN
    sel_rep = 1'b0;
    if (!sel_found && rep_pend) begin
      sel_found = 1'b1;
      sel_rep   = 1'b1;
      sel_code  = rep_code;
    end
`endif
  end

  assign full = (count == CNTW'(FIFO_DEPTH));
  assign pop  = key_valid && key_ready;
  assign push = sel_found && (!full || pop);

`ifdef KEY_REPEAT_EN
  assign clr_press = (push && !sel_rel && !sel_rep) ? (NK'(1) << sel_code) : '0;
  assign clr_rel   = (push && sel_rel) ? (NK'(1) << sel_code) : '0;
  assign clr_rep   = push && sel_rep;
  assign push_data = {sel_rep, sel_rel, sel_code};
`else
  assign clr_press = (push && !sel_rel) ? (NK'(1) << sel_code) : '0;
  assign clr_rel   = (push && sel_rel) ? (NK'(1) << sel_code) : '0;
  assign push_data = {sel_rel, sel_code};
`endif

  // A flag being pushed this cycle frees its slot, so a new edge there is not a loss.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      press_pend <= '0;
      rel_pend   <= '0;
      overflow   <= 1'b0;
    end else begin
      press_pend <= (press_pend & ~clr_press) | rise;
      rel_pend   <= (rel_pend & ~clr_rel) | fall;
      if (|(rise & press_pend & ~clr_press) || |(fall & rel_pend & ~clr_rel))
        overflow <= 1'b1;
    end
  end

`ifdef KEY_REPEAT_EN
  logic          low_found;
  logic [3:0]    low_code;
  logic          rep_active, rep_first;
  logic [3:0]    rep_key;
  logic [RW-1:0] rep_cnt, rep_target;

  always_comb begin
    low_found = 1'b0;
    low_code  = 4'd0;
    for (int n = 0; n < NK; n++) begin
      if (!low_found && deb[n]) begin
        low_found = 1'b1;
        low_code  = 4'(n);
      end
    end
  end

  assign rep_target = rep_first ? RW'(REPEAT_DELAY) : RW'(REPEAT_PERIOD);

  // Repeat timer follows the lowest held key; a repeat landing on a pending one is discarded.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rep_active <= 1'b0;
      rep_first  <= 1'b1;
      rep_key    <= 4'd0;
      rep_cnt    <= '0;
      rep_pend   <= 1'b0;
      rep_code   <= 4'd0;
    end else begin
      rep_pend <= rep_pend && !clr_rep;
      if (!low_found) begin
        rep_active <= 1'b0;
        rep_cnt    <= '0;
      end else if (!rep_active || low_code != rep_key) begin
        rep_active <= 1'b1;
        rep_first  <= 1'b1;
        rep_key    <= low_code;
        rep_cnt    <= '0;
      end else if (rep_cnt + RW'(1) == rep_target) begin
        rep_cnt   <= '0;
        rep_first <= 1'b0;
        rep_pend  <= 1'b1;
        if (!rep_pend || clr_rep) rep_code <= rep_key;
      end else begin
        rep_cnt <= rep_cnt + RW'(1);
      end
    end
  end
`endif

  // Handshake: an event transfers on a rising CLK edge with key_valid and key_ready both
  // high; while key_valid is high and key_ready low the head event holds steady.
  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [EW-1:0] head;

  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CNTW'(1);
        2'b01:   count <= count - CNTW'(1);
        default: count <= count;
      endcase
    end
  end

  assign head        = mem[rd_ptr];
  assign key_valid   = (count != '0);
  assign key_code    = key_valid ? head[3:0] : 4'd0;
  assign key_release = key_valid && head[4];
`ifdef KEY_REPEAT_EN
  assign key_repeat  = key_valid && head[5];
`else
  assign key_repeat  = 1'b0;
`endif

endmodule
